range_tracker: RTL and testbench

- Windowed streaming statistics block and the parametrised successor to the team's single-range finder.
- Between a go and a finish it tracks min, max, range and sample count of a qualified data stream.
- Supports signed or unsigned compare, and holds results in a DONE state with a valid flag.
- Flags protocol errors. Sits between a sample source (ADC or sensor front end) and a readout/controller.

---
 rtl/range_tracker_pkg.sv | 24 ++
 rtl/range_tracker_minmax.sv | 29 ++
 rtl/range_tracker.sv | 114 +++++++++++
 tb/tb_range_tracker.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/range_tracker_pkg.sv
// Shared state encoding and compare helper for the range tracker.
package range_tracker_pkg;

    // Widest sample the compare helper accepts.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // a < b over the low w bits. Operands arrive zero-extended; for a signed
    // compare, flipping bit w-1 maps two's-complement order onto unsigned order.
    function automatic logic lt_fn(input logic             is_signed,
                                   input int unsigned      w,
                                   input logic [MAX_W-1:0] a,
                                   input logic [MAX_W-1:0] b);
        logic [MAX_W-1:0] flip;
        flip = is_signed ? (MAX_W'(1) << (w - 1)) : '0;
        return (a ^ flip) < (b ^ flip);
    endfunction

endpackage

// File: rtl/range_tracker_minmax.sv
// Combinational next-min/next-max for a single incoming sample.
module minmax_update
    import range_tracker_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] sample_i,
    input  logic [WIDTH-1:0] min_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic             empty_i,
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] max_o
);

    // First sample seeds both extremes; later samples only widen them.
    always_comb begin
        min_o = min_i;
        max_o = max_i;
        if (empty_i) begin
            min_o = sample_i;
            max_o = sample_i;
        end else begin
            if (lt_fn(SIGNED, WIDTH, MAX_W'(sample_i), MAX_W'(min_i))) min_o = sample_i;
            if (lt_fn(SIGNED, WIDTH, MAX_W'(max_i), MAX_W'(sample_i))) max_o = sample_i;
        end
    end

endmodule

// File: rtl/range_tracker.sv
// Windowed min/max/range/count tracker with go/finish framing and a sticky protocol error.
module range_tracker
    import range_tracker_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter bit          SIGNED = 1'b0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    input  logic             go,
    input  logic             finish,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [WIDTH-1:0] range,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             result_valid,
    output logic             empty,
    output logic             debug_error
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d, range_q, range_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d, err_q, err_d;
    logic             accept_go;
    logic [WIDTH-1:0] upd_min, upd_max;

    // A go is honoured only outside RUN and only without a simultaneous finish.
    assign accept_go = (state_q != ST_RUN) && go && !finish;

    minmax_update #(
        .WIDTH  (WIDTH),
        .SIGNED (SIGNED)
    ) u_minmax (
        .sample_i (data_in),
        .min_i    (min_q),
        .max_i    (max_q),
        .empty_i  (empty_q || accept_go),
        .min_o    (upd_min),
        .max_o    (upd_max)
    );

    // Next-state for window framing, statistics, counter and error flag.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        empty_d = empty_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                if (data_valid) begin
                    min_d   = upd_min;
                    max_d   = upd_max;
                    empty_d = 1'b0;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end
                if (finish) state_d = ST_DONE;
            end
            default: begin
                if (accept_go) begin
                    state_d = ST_RUN;
                    err_d   = 1'b0;
                    empty_d = !data_valid;
                    cnt_d   = data_valid ? CNT_W'(1) : '0;
                    min_d   = data_valid ? upd_min : '0;
                    max_d   = data_valid ? upd_max : '0;
                end else if (finish) begin
                    err_d = 1'b1;
                end
            end
        endcase
        // Built from next-state extremes so range tracks min/max in the same cycle.
        range_d = max_d - min_d;
    end

    // State and result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            min_q   <= '0;
            max_q   <= '0;
            range_q <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            range_q <= range_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    assign min_out      = min_q;
    assign max_out      = max_q;
    assign range        = range_q;
    assign count        = cnt_q;
    assign busy         = (state_q == ST_RUN);
    assign result_valid = (state_q == ST_DONE);
    assign empty        = empty_q;
    assign debug_error  = err_q;

endmodule

// File: tb/tb_range_tracker.sv
// Directed bench: table-driven window sequence plus signed, saturation and reset cases.
module tb_range_tracker;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Instance A: 16-bit unsigned, 16-bit counter.
    logic        a_go, a_fin, a_dv;
    logic [15:0] a_d, a_min, a_max, a_rng, a_cnt;
    logic        a_busy, a_rv, a_empty, a_err;

    // Instance B: 8-bit signed.
    logic        b_go, b_fin, b_dv;
    logic [7:0]  b_d, b_min, b_max, b_rng;
    logic [15:0] b_cnt;
    logic        b_busy, b_rv, b_empty, b_err;

    // Instance C: 16-bit unsigned, 3-bit counter.
    logic        c_go, c_fin, c_dv;
    logic [15:0] c_d, c_min, c_max, c_rng;
    logic [2:0]  c_cnt;
    logic        c_busy, c_rv, c_empty, c_err;

    range_tracker #(.WIDTH(16), .SIGNED(1'b0), .CNT_W(16)) dut_a (
        .clock(clk), .reset(rst), .data_in(a_d), .data_valid(a_dv), .go(a_go), .finish(a_fin),
        .min_out(a_min), .max_out(a_max), .range(a_rng), .count(a_cnt), .busy(a_busy),
        .result_valid(a_rv), .empty(a_empty), .debug_error(a_err));

    range_tracker #(.WIDTH(8), .SIGNED(1'b1), .CNT_W(16)) dut_b (
        .clock(clk), .reset(rst), .data_in(b_d), .data_valid(b_dv), .go(b_go), .finish(b_fin),
        .min_out(b_min), .max_out(b_max), .range(b_rng), .count(b_cnt), .busy(b_busy),
        .result_valid(b_rv), .empty(b_empty), .debug_error(b_err));

    range_tracker #(.WIDTH(16), .SIGNED(1'b0), .CNT_W(3)) dut_c (
        .clock(clk), .reset(rst), .data_in(c_d), .data_valid(c_dv), .go(c_go), .finish(c_fin),
        .min_out(c_min), .max_out(c_max), .range(c_rng), .count(c_cnt), .busy(c_busy),
        .result_valid(c_rv), .empty(c_empty), .debug_error(c_err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        go, fin, dv;
        logic [15:0] d;
        logic [15:0] emin, emax, erng, ecnt;
        logic        ebusy, erv, eempty, eerr;
    } vec_t;

    function automatic vec_t mk(input logic go, fin, dv, input int d,
                                input int emin, emax, erng, ecnt,
                                input logic ebusy, erv, eempty, eerr);
        vec_t v;
        v.go = go; v.fin = fin; v.dv = dv; v.d = 16'(d);
        v.emin = 16'(emin); v.emax = 16'(emax); v.erng = 16'(erng); v.ecnt = 16'(ecnt);
        v.ebusy = ebusy; v.erv = erv; v.eempty = eempty; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input int emin, emax, erng, ecnt,
                         input logic ebusy, erv, eempty, eerr);
        chk({tag, ".min"},   32'(a_min),   32'(emin));
        chk({tag, ".max"},   32'(a_max),   32'(emax));
        chk({tag, ".range"}, 32'(a_rng),   32'(erng));
        chk({tag, ".count"}, 32'(a_cnt),   32'(ecnt));
        chk({tag, ".busy"},  32'(a_busy),  32'(ebusy));
        chk({tag, ".rv"},    32'(a_rv),    32'(erv));
        chk({tag, ".empty"}, 32'(a_empty), 32'(eempty));
        chk({tag, ".err"},   32'(a_err),   32'(eerr));
    endtask

    vec_t vecs[16];

    initial begin
        checks = 0;
        errors = 0;
        {a_go, a_fin, a_dv, a_d} = '0;
        {b_go, b_fin, b_dv, b_d} = '0;
        {c_go, c_fin, c_dv, c_d} = '0;
        rst = 1'b1;

        //              go fin dv data   min max rng cnt busy rv empty err
        vecs[0]  = mk(1, 0, 1, 50,    50, 50,  0, 1, 1, 0, 0, 0);
        vecs[1]  = mk(0, 0, 1, 20,    20, 50, 30, 2, 1, 0, 0, 0);
        vecs[2]  = mk(0, 0, 1, 90,    20, 90, 70, 3, 1, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 40,    20, 90, 70, 4, 1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0,     20, 90, 70, 4, 0, 1, 0, 0);
        vecs[5]  = mk(0, 0, 1, 5,     20, 90, 70, 4, 0, 1, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0,     20, 90, 70, 4, 0, 1, 0, 1);
        vecs[7]  = mk(0, 1, 0, 0,     20, 90, 70, 4, 0, 1, 0, 1);
        vecs[8]  = mk(1, 0, 0, 0,      0,  0,  0, 0, 1, 0, 1, 0);
        vecs[9]  = mk(1, 0, 1, 7,      7,  7,  0, 1, 1, 0, 0, 0);
        vecs[10] = mk(1, 1, 1, 3,      3,  7,  4, 2, 0, 1, 0, 0);
        vecs[11] = mk(1, 0, 0, 0,      0,  0,  0, 0, 1, 0, 1, 0);
        vecs[12] = mk(0, 0, 0, 0,      0,  0,  0, 0, 1, 0, 1, 0);
        vecs[13] = mk(0, 0, 0, 0,      0,  0,  0, 0, 1, 0, 1, 0);
        vecs[14] = mk(0, 0, 0, 0,      0,  0,  0, 0, 1, 0, 1, 0);
        vecs[15] = mk(0, 1, 0, 0,      0,  0,  0, 0, 0, 1, 1, 0);

        // Reset values
        step();
        step();
        chk_a("rst_a", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_b.empty", 32'(b_empty), 32'd1);
        chk("rst_c.count", 32'(c_cnt), 32'd0);
        rst = 1'b0;

        // Table-driven window sequence on instance A
        for (int i = 0; i < 16; i++) begin
            a_go = vecs[i].go; a_fin = vecs[i].fin; a_dv = vecs[i].dv; a_d = vecs[i].d;
            step();
            chk_a($sformatf("vec%0d", i), int'(vecs[i].emin), int'(vecs[i].emax),
                  int'(vecs[i].erng), int'(vecs[i].ecnt), vecs[i].ebusy, vecs[i].erv,
                  vecs[i].eempty, vecs[i].eerr);
        end
        {a_go, a_fin, a_dv, a_d} = '0;

        // Async reset in the middle of a window
        a_go = 1'b1; a_dv = 1'b1; a_d = 16'd1234;
        step();
        {a_go, a_fin, a_dv, a_d} = '0;
        chk("pre_rst.busy", 32'(a_busy), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk_a("async_rst", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 rst = 1'b0;

        // finish in IDLE: sticky error, state stays IDLE, next go clears
        a_fin = 1'b1;
        step();
        a_fin = 1'b0;
        chk_a("idle_fin", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        chk("idle_fin_sticky.err", 32'(a_err), 32'd1);
        a_go = 1'b1;
        step();
        a_go = 1'b0;
        chk_a("go_clears", 0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0);

        // Signed window on instance B: -100, 27, -5
        b_go = 1'b1; b_dv = 1'b1; b_d = 8'h9C;
        step();
        b_go = 1'b0; b_d = 8'd27;
        step();
        b_d = 8'hFB;
        step();
        b_dv = 1'b0; b_fin = 1'b1;
        step();
        b_fin = 1'b0;
        chk("signed.min",   32'(b_min), 32'h9C);
        chk("signed.max",   32'(b_max), 32'd27);
        chk("signed.range", 32'(b_rng), 32'd127);
        chk("signed.count", 32'(b_cnt), 32'd3);
        chk("signed.rv",    32'(b_rv),  32'd1);

        // Signed extreme span: -128 and 127
        b_go = 1'b1; b_dv = 1'b1; b_d = 8'h80;
        step();
        b_go = 1'b0; b_d = 8'h7F; b_fin = 1'b1;
        step();
        b_dv = 1'b0; b_fin = 1'b0;
        chk("extreme.min",   32'(b_min), 32'h80);
        chk("extreme.max",   32'(b_max), 32'h7F);
        chk("extreme.range", 32'(b_rng), 32'd255);
        chk("extreme.rv",    32'(b_rv),  32'd1);

        // Saturating 3-bit counter with gaps on instance C
        begin
            logic [15:0] samples [10];
            samples = '{16'd500, 16'd300, 16'd700, 16'd100, 16'd900,
                        16'd200, 16'd800, 16'd50,  16'd600, 16'd1000};
            c_go = 1'b1; c_dv = 1'b1; c_d = samples[0];
            step();
            c_go = 1'b0;
            for (int i = 1; i < 10; i++) begin
                c_dv = 1'b0;
                step();
                c_dv = 1'b1; c_d = samples[i];
                step();
                if (i == 6) chk("sat7.count", 32'(c_cnt), 32'd7);
                if (i == 7) chk("sat8.count", 32'(c_cnt), 32'd7);
            end
            c_dv = 1'b0; c_fin = 1'b1;
            step();
            c_fin = 1'b0;
            chk("sat.count", 32'(c_cnt), 32'd7);
            chk("sat.min",   32'(c_min), 32'd50);
            chk("sat.max",   32'(c_max), 32'd1000);
            chk("sat.range", 32'(c_rng), 32'd950);
            chk("sat.rv",    32'(c_rv),  32'd1);
            chk("sat.err",   32'(c_err), 32'd0);
            chk("sat.busy",  32'(c_busy), 32'd0);
            chk("sat.empty", 32'(c_empty), 32'd0);
        end

        chk("b.err", 32'(b_err), 32'd0);
        chk("b.busy", 32'(b_busy), 32'd0);
        chk("b.empty", 32'(b_empty), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
